// File: rtl/ca_code_gen.sv
// rtl/ca_code_gen.sv - GPS L1 C/A Gold-code generator, one chip per chip_en tick
module ca_code_gen #(
    parameter int PRN_RST = 1,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chip_en,
    input  logic             restart,
    input  logic [5:0]       prn,
    output logic             chip_out,
    output logic [CNT_W-1:0] chip_cnt,
    output logic             epoch,
    output logic [5:0]       prn_active,
    output logic             prn_err
);

    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(1022);

    // G2 phase-selector taps for each PRN, returned as a mask over stages 10..1
    function automatic logic [10:1] tap_mask(input logic [5:0] p);
        int a;
        int b;
        case (p)
            6'd1:  begin a = 2; b = 6;  end
            6'd2:  begin a = 3; b = 7;  end
            6'd3:  begin a = 4; b = 8;  end
            6'd4:  begin a = 5; b = 9;  end
            6'd5:  begin a = 1; b = 9;  end
            6'd6:  begin a = 2; b = 10; end
            6'd7:  begin a = 1; b = 8;  end
            6'd8:  begin a = 2; b = 9;  end
            6'd9:  begin a = 3; b = 10; end
            6'd10: begin a = 2; b = 3;  end
            6'd11: begin a = 3; b = 4;  end
            6'd12: begin a = 5; b = 6;  end
            6'd13: begin a = 6; b = 7;  end
            6'd14: begin a = 7; b = 8;  end
            6'd15: begin a = 8; b = 9;  end
            6'd16: begin a = 9; b = 10; end
            6'd17: begin a = 1; b = 4;  end
            6'd18: begin a = 2; b = 5;  end
            6'd19: begin a = 3; b = 6;  end
            6'd20: begin a = 4; b = 7;  end
            6'd21: begin a = 5; b = 8;  end
            6'd22: begin a = 6; b = 9;  end
            6'd23: begin a = 1; b = 3;  end
            6'd24: begin a = 4; b = 6;  end
            6'd25: begin a = 5; b = 7;  end
            6'd26: begin a = 6; b = 8;  end
            6'd27: begin a = 7; b = 9;  end
            6'd28: begin a = 8; b = 10; end
            6'd29: begin a = 1; b = 6;  end
            6'd30: begin a = 2; b = 7;  end
            6'd31: begin a = 3; b = 8;  end
            6'd32: begin a = 4; b = 9;  end
            default: begin a = 2; b = 6; end
        endcase
        tap_mask = (10'd1 << (a - 1)) | (10'd1 << (b - 1));
    endfunction

    logic [10:1]      g1, g2;
    logic [10:1]      g1_n, g2_n;
    logic [CNT_W-1:0] cnt_n;
    logic [5:0]       prn_n;
    logic             epoch_n, err_n, chip_n;
    logic             prn_legal;
    logic             g1_fb, g2_fb;

    assign prn_legal = (prn >= 6'd1) && (prn <= 6'd32);
    assign g1_fb     = g1[3] ^ g1[10];
    assign g2_fb     = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];

    always_comb begin
        g1_n    = g1;
        g2_n    = g2;
        cnt_n   = chip_cnt;
        prn_n   = prn_active;
        epoch_n = 1'b0;
        err_n   = 1'b0;
        if (restart) begin
            // restart always consumes the cycle, so a coincident chip_en is dropped
            if (prn_legal) begin
                prn_n = prn;
                g1_n  = '1;
                g2_n  = '1;
                cnt_n = '0;
            end else begin
                err_n = 1'b1;
            end
        end else if (chip_en) begin
            if (chip_cnt == LAST_CHIP) begin
                g1_n    = '1;
                g2_n    = '1;
                cnt_n   = '0;
                epoch_n = 1'b1;
            end else begin
                g1_n  = {g1[9:1], g1_fb};
                g2_n  = {g2[9:1], g2_fb};
                cnt_n = chip_cnt + 1'b1;
            end
        end
        chip_n = g1_n[10] ^ (^(g2_n & tap_mask(prn_n)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g1         <= '1;
            g2         <= '1;
            chip_cnt   <= '0;
            prn_active <= 6'(PRN_RST);
            epoch      <= 1'b0;
            prn_err    <= 1'b0;
            // all-ones registers: both selected G2 taps cancel, leaving G1[10]
            chip_out   <= 1'b1;
        end else begin
            g1         <= g1_n;
            g2         <= g2_n;
            chip_cnt   <= cnt_n;
            prn_active <= prn_n;
            epoch      <= epoch_n;
            prn_err    <= err_n;
            chip_out   <= chip_n;
        end
    end

endmodule

// File: tb/tb_ca_code_gen.sv
// tb/tb_ca_code_gen.sv - scoreboard bench for ca_code_gen
module tb_ca_code_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       chip_en = 1'b0;
    logic       restart = 1'b0;
    logic [5:0] prn = 6'd0;
    logic       chip_out;
    logic [9:0] chip_cnt;
    logic       epoch;
    logic [5:0] prn_active;
    logic       prn_err;

    ca_code_gen #(.PRN_RST(1), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .chip_en(chip_en), .restart(restart), .prn(prn),
        .chip_out(chip_out), .chip_cnt(chip_cnt), .epoch(epoch),
        .prn_active(prn_active), .prn_err(prn_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kc;
        logic       chip;
        int         cnt;
        logic       ep;
        logic [5:0] p;
        logic       er;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [9:0] pat1, pat2, pat4, m_pat;
    int         m_cnt;
    logic [5:0] m_prn;
    logic       evt = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic kc, input logic ch, input int c, input logic ep,
                        input logic [5:0] p, input logic er);
        exp_t e;
        e.kc = kc; e.chip = ch; e.cnt = c; e.ep = ep; e.p = p; e.er = er;
        q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_chip_out"}, chip_out, 1);
        check({tag, "_chip_cnt"}, chip_cnt, 0);
        check({tag, "_prn_active"}, prn_active, 1);
        check({tag, "_epoch"}, epoch, 0);
        check({tag, "_prn_err"}, prn_err, 0);
    endtask

    // response appears the cycle after an edge that saw chip_en or restart
    always @(posedge clk) evt <= rst && (chip_en || restart);

    always @(negedge clk) begin
        if (rst) begin
            if (evt) begin
                if (q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.kc) check("chip_out", chip_out, e.chip);
                    check("chip_cnt", chip_cnt, e.cnt);
                    check("epoch", epoch, e.ep);
                    check("prn_active", prn_active, e.p);
                    check("prn_err", prn_err, e.er);
                end
            end else if (epoch || prn_err) begin
                check("idle_pulse", {30'd0, epoch, prn_err}, 0);
            end
        end
    end

    task automatic ticks(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            m_cnt = (m_cnt == 1022) ? 0 : m_cnt + 1;
            push(m_cnt <= 9, (m_cnt <= 9) ? m_pat[9 - ((m_cnt <= 9) ? m_cnt : 0)] : 1'b0,
                 m_cnt, m_cnt == 0, m_prn, 1'b0);
            chip_en = 1'b1;
            @(posedge clk) #1;
            chip_en = 1'b0;
            repeat (gap) @(posedge clk) #1;
        end
    endtask

    task automatic restart_req(input logic [5:0] p, input logic with_en, input logic [9:0] pat);
        if (p >= 6'd1 && p <= 6'd32) begin
            m_prn = p;
            m_cnt = 0;
            m_pat = pat;
            push(1'b1, pat[9], 0, 1'b0, p, 1'b0);
        end else begin
            push(m_cnt <= 9, m_pat[9 - ((m_cnt <= 9) ? m_cnt : 0)], m_cnt, 1'b0, m_prn, 1'b1);
        end
        restart = 1'b1;
        prn     = p;
        chip_en = with_en;
        @(posedge clk) #1;
        restart = 1'b0;
        chip_en = 1'b0;
        repeat (2) @(posedge clk) #1;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (q.size() != 0 && budget > 0) begin
            @(posedge clk) #1;
            budget--;
        end
        check({name, "_drain"}, q.size(), 0);
    endtask

    initial begin
        pat1 = 10'o1440;
        pat2 = 10'o1620;
        pat4 = 10'o1744;
        m_pat = pat1;
        m_cnt = 0;
        m_prn = 6'd1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        @(posedge clk) #1;
        check_reset_state("release");

        ticks(10, 2);
        drain("prn1");

        restart_req(6'd2, 1'b0, pat2);
        ticks(10, 2);
        drain("prn2");

        restart_req(6'd2, 1'b0, pat2);
        ticks(2046, 0);
        drain("two_epochs");

        restart_req(6'd0, 1'b0, pat2);
        restart_req(6'd33, 1'b0, pat2);
        restart_req(6'd40, 1'b1, pat2);
        drain("illegal_prn");

        restart_req(6'd4, 1'b1, pat4);
        ticks(9, 1);
        ticks(491, 0);
        drain("prn4_to_500");
        check("pre_reset_cnt", chip_cnt, 500);

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(posedge clk) #1;
        check_reset_state("held_reset");
        rst = 1'b1;
        m_pat = pat1;
        m_cnt = 0;
        m_prn = 6'd1;
        @(posedge clk) #1;
        check_reset_state("rerelease");
        ticks(5, 1);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
